// File: rtl/multicycle_ctrl_hs_pkg.sv
// Shared codes for the multi-cycle controller:
// state encodings, opcodes and ALU operand/op selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    RESET_S = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    ASN     = 4'd3,
    ALU_WB  = 4'd4,
    SHIFT   = 4'd5,
    ORI_RD  = 4'd6,
    ORI_EX  = 4'd7,
    ORI_WB  = 4'd8,
    LD_MEM  = 4'd9,
    LD_WB   = 4'd10,
    ST_MEM  = 4'd11,
    BR      = 4'd12,
    HALT    = 4'd13
  } state_e;

  localparam logic [3:0] OP_LOAD    = 4'b0000;
  localparam logic [3:0] OP_STORE   = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0100;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_NAND    = 4'b1000;
  localparam logic [3:0] OP_BPZ     = 4'b1101;
  localparam logic [3:0] OP_BZ      = 4'b0101;
  localparam logic [3:0] OP_BNZ     = 4'b1001;
  localparam logic [3:0] OP_NOPSTOP = 4'b0001;
  localparam logic [2:0] SFX_SHIFT  = 3'b011;
  localparam logic [2:0] SFX_ORI    = 3'b111;

  localparam logic [2:0] A2_R2    = 3'b000;
  localparam logic [2:0] A2_ONE   = 3'b001;
  localparam logic [2:0] A2_SIMM4 = 3'b010;
  localparam logic [2:0] A2_ZIMM5 = 3'b011;
  localparam logic [2:0] A2_SHAMT = 3'b100;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_NAND  = 3'b011;
  localparam logic [2:0] ALU_SHIFT = 3'b100;

  function automatic logic is_asn(input logic [3:0] op);
    return op == OP_ADD || op == OP_SUB || op == OP_NAND;
  endfunction

  function automatic logic is_br(input logic [3:0] op);
    return op == OP_BPZ || op == OP_BZ || op == OP_BNZ;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_hs_sat_counter.sv
// Up-counter that sticks at all-ones; cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multi-cycle control FSM with memory handshake,
// resumable HALT and saturating debug counters.
module multicycle_ctrl_hs #(
  parameter int CNT_W        = 16,
  parameter int MEM_HS       = 1,
  parameter int ILLEGAL_HALT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       instr,
  input  logic             NOP,
  input  logic             N,
  input  logic             Z,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             PCwrite,
  output logic             AddrSel,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRload,
  output logic             R1Sel,
  output logic             MDRload,
  output logic             R1R2Load,
  output logic             ALU1,
  output logic             ALUOutWrite,
  output logic             RFWrite,
  output logic             RegIn,
  output logic             FlagWrite,
  output logic [2:0]       ALU2,
  output logic [2:0]       ALUop,
  output logic [3:0]       ostate,
  output logic             instr_done,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  import ctrl_pkg::*;

  state_e state_d, state_q;
  logic   rdy;
  logic   cyc_inc;

  assign rdy = (MEM_HS != 0) ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_S: state_d = FETCH;
      FETCH:   if (rdy) state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_asn(instr):           state_d = ASN;
          instr[2:0] == SFX_SHIFT: state_d = SHIFT;
          instr[2:0] == SFX_ORI:   state_d = ORI_RD;
          instr == OP_LOAD:        state_d = LD_MEM;
          instr == OP_STORE:       state_d = ST_MEM;
          is_br(instr):            state_d = BR;
          instr == OP_NOPSTOP:     state_d = NOP ? FETCH : HALT;
          default:
            state_d = (ILLEGAL_HALT != 0) ? HALT : RESET_S;
        endcase
      end
      ASN, SHIFT: state_d = ALU_WB;
      ALU_WB:     state_d = FETCH;
      ORI_RD:     state_d = ORI_EX;
      ORI_EX:     state_d = ORI_WB;
      ORI_WB:     state_d = FETCH;
      LD_MEM:     if (rdy) state_d = LD_WB;
      LD_WB:      state_d = FETCH;
      ST_MEM:     if (rdy) state_d = FETCH;
      BR:         state_d = FETCH;
      HALT:       if (resume) state_d = FETCH;
      default:    state_d = RESET_S;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= RESET_S;
    else       state_q <= state_d;
  end

  // Controls decode straight off the state so reset clears them at once
  always_comb begin
    PCwrite     = 1'b0;
    AddrSel     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRload      = 1'b0;
    R1Sel       = 1'b0;
    MDRload     = 1'b0;
    R1R2Load    = 1'b0;
    ALU1        = 1'b0;
    ALUOutWrite = 1'b0;
    RFWrite     = 1'b0;
    RegIn       = 1'b0;
    FlagWrite   = 1'b0;
    ALU2        = A2_R2;
    ALUop       = ALU_ADD;
    instr_done  = 1'b0;
    halted      = 1'b0;
    case (state_q)
      FETCH: begin
        AddrSel = 1'b1;
        MemRead = 1'b1;
        ALU2    = A2_ONE;
        PCwrite = rdy;
        IRload  = rdy;
      end
      DECODE: begin
        R1R2Load   = 1'b1;
        instr_done = (instr == OP_NOPSTOP);
      end
      ASN: begin
        ALU1        = 1'b1;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
        if (instr == OP_SUB)  ALUop = ALU_SUB;
        if (instr == OP_NAND) ALUop = ALU_NAND;
      end
      SHIFT: begin
        ALU1        = 1'b1;
        ALU2        = A2_SHAMT;
        ALUop       = ALU_SHIFT;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
      end
      ALU_WB: begin
        RFWrite    = 1'b1;
        instr_done = 1'b1;
      end
      ORI_RD: begin
        R1Sel    = 1'b1;
        R1R2Load = 1'b1;
      end
      ORI_EX: begin
        ALU1        = 1'b1;
        ALU2        = A2_ZIMM5;
        ALUop       = ALU_OR;
        ALUOutWrite = 1'b1;
        FlagWrite   = 1'b1;
      end
      ORI_WB: begin
        R1Sel      = 1'b1;
        RFWrite    = 1'b1;
        instr_done = 1'b1;
      end
      LD_MEM: begin
        MemRead = 1'b1;
        MDRload = rdy;
      end
      LD_WB: begin
        RFWrite     = 1'b1;
        RegIn       = 1'b1;
        ALUOutWrite = 1'b1;
        instr_done  = 1'b1;
      end
      ST_MEM: begin
        MemWrite   = 1'b1;
        instr_done = rdy;
      end
      BR: begin
        ALU2       = A2_SIMM4;
        instr_done = 1'b1;
        if (instr == OP_BPZ) PCwrite = ~N;
        if (instr == OP_BZ)  PCwrite = Z;
        if (instr == OP_BNZ) PCwrite = ~Z;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  assign ostate  = state_q;
  assign cyc_inc = state_q != RESET_S && state_q != HALT;

  sat_counter #(.W(CNT_W)) u_cyc (
    .clock (clock),
    .reset (reset),
    .inc   (cyc_inc),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_ins (
    .clock (clock),
    .reset (reset),
    .inc   (instr_done),
    .count (instr_count)
  );

endmodule
